vend_controller: RTL
====================

# vend_controller

Transaction sequencer for the vending machine. Sits between the board-input conditioning (debounced, edge-detected coin/select/cancel pulses) and the display/indicator logic. Owns the credit balance, decides accept/reject for coins, arbitrates product selection against price, times the dispense, and issues change. The seven-segment driver reads `balance`; `get`/`back`/`used` drive the board LEDs.

## Interface
- `PRICE0`, default 2: price of product 0, yuan
- `PRICE1`, default 3: price of product 1
- `PRICE2`, default 5: price of product 2
- `PRICE3`, default 7: price of product 3
- `BAL_MAX`, default 99: maximum balance, matching the two-digit display
- `DISP_CYCLES`, default 4: cycles `get` is held per dispense, ≥1
- `clk` in 1: system clock; the only clock
- `reset` in 1: synchronous, active-low reset
- `one`, `two`, `five`, `ten` in 1 each: single-cycle coin pulses, values 1/2/5/10
- `p0`, `p1`, `p2`, `p3` in 1 each: single-cycle product-select pulses
- `cancel` in 1: single-cycle refund request
- `balance` out 8: current credit, binary
- `used` out 1: high whenever the state is not IDLE
- `get` out 1: dispense strobe, held `DISP_CYCLES` cycles
- `prod` out 2: index of the product being dispensed; valid while `get` is high
- `back` out 1: one-cycle change strobe
- `change` out 8: change amount; valid while `back` is high, holds its value until the next `back`
- `reject` out 1: one-cycle pulse when a coin is returned unaccepted
- `short` out 1: one-cycle pulse when a select is refused for insufficient credit

## Operation
- States: IDLE (balance 0), CREDIT (balance > 0), DISPENSE, CHANGE.
- **Coins** are accepted only in IDLE or CREDIT.
  - If more than one coin pulses in the same cycle, only the highest value is accepted and `reject` pulses.
  - If `balance + coin > BAL_MAX`, the coin is refused, `reject` pulses and the balance is unchanged.
  - An accepted coin moves IDLE to CREDIT.
- **Selects** are honoured only in CREDIT.
  - If several selects pulse together, the lowest index wins.
  - If `balance ≥ PRICEn`: `balance <= balance − PRICEn`, `prod <= n`, go to DISPENSE.
  - Otherwise `short` pulses and the state stays CREDIT.
- **Coin and select in the same cycle:** the select is evaluated against the old balance, and the coin is rejected.
- **Cancel** in CREDIT moves to CHANGE.
  - Cancel in IDLE is ignored.
  - Cancel beats select and coin in the same cycle; a coproduced coin gets `reject`.
- **DISPENSE:** `get` is high for exactly `DISP_CYCLES` cycles.
  - Then go to CHANGE if `balance > 0`, else IDLE.
  - Coins pulsed here get `reject`; selects and cancel are ignored.
- **CHANGE:** lasts one cycle.
  - `back = 1` and `change = balance`.
  - The next cycle has `balance = 0` and the state is IDLE.
  - Coins pulsed here get `reject`.
- **Arithmetic:** 8-bit unsigned. `balance` never exceeds `BAL_MAX`, and the subtract never underflows because it is guarded by the compare.
- **Reset** is valid in any state, including mid-dispense. The machine goes to IDLE with no pending change emitted and no credit kept.

## Timing
- Reset values: state IDLE; `balance`, `change`, `prod` are 0; `used`, `get`, `back`, `reject`, `short` are 0.
- Coin pulse at cycle t: `balance` updates at t+1, and `reject` (if any) is high during t+1.
- Accepted select at t:
  - `get` is high at t+1 … t+`DISP_CYCLES`, with `balance` already reduced at t+1.
  - `back` comes at t+`DISP_CYCLES`+1 if there is a remainder.
  - IDLE is reached one cycle after `back`, or directly after the last `get` cycle if there is no remainder.
- Cancel at t: `back` and `change` at t+1; IDLE with `balance = 0` at t+2.
- All outputs are registered and there are no combinational input-to-output paths.

## Structure
- Shared package `vend_pkg` holds:
  - the state enum (IDLE, CREDIT, DISPENSE, CHANGE);
  - coin value constants (1, 2, 5, 10);
  - `BAL_W = 8`.
- One sub-module, `vend_coin_enc`: a combinational priority encoder from the four coin pulses to `{valid, multi, value[3:0]}`.
- The dispense timer is a local down-counter sized `$clog2(DISP_CYCLES+1)`.

## Test plan
- Coins 1, 2, 5, then p1 (price 3):
  - `balance` goes 1 → 3 → 8.
  - `get` is high 4 cycles with `prod = 1`.
  - Then `back = 1` with `change = 5`, and the state returns to IDLE.
- `balance = 2`, p2 (price 5): `short` pulses one cycle, balance stays 2, no `get`.
- `balance = 95`, coin 10:
  - `reject` pulses and the balance stays 95.
  - Coin 2 is then accepted, giving `balance = 97`.
- `five` and `ten` in the same cycle from IDLE: `balance = 10` and `reject` pulses.
- `balance = 7`, cancel and p0 in the same cycle: `back` with `change = 7`, no `get`, IDLE two cycles later.
- Mid-dispense `reset` low for one cycle:
  - All outputs read 0 on the next cycle, with no `back`.
  - A subsequent coin 1 gives `balance = 1`.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared types and constants for the vending-machine transaction sequencer.
package vend_pkg;

  localparam int unsigned BAL_W = 8;

  localparam logic [3:0] COIN_ONE  = 4'd1;
  localparam logic [3:0] COIN_TWO  = 4'd2;
  localparam logic [3:0] COIN_FIVE = 4'd5;
  localparam logic [3:0] COIN_TEN  = 4'd10;

  typedef enum logic [1:0] {
    StIdle,
    StCredit,
    StDispense,
    StChange
  } vend_state_e;

endpackage

// File: rtl/vend_coin_enc.sv
// Priority encoder from the four coin pulses: highest value wins, multi flags a collision.
module vend_coin_enc
  import vend_pkg::*;
(
  input  logic       one,
  input  logic       two,
  input  logic       five,
  input  logic       ten,
  output logic       valid,
  output logic       multi,
  output logic [3:0] value
);

  always_comb begin
    value = 4'd0;
    if (ten) begin
      value = COIN_TEN;
    end else if (five) begin
      value = COIN_FIVE;
    end else if (two) begin
      value = COIN_TWO;
    end else if (one) begin
      value = COIN_ONE;
    end
  end

  assign valid = one | two | five | ten;
  assign multi = !$onehot0({ten, five, two, one});

endmodule

// File: rtl/vend_controller.sv
// Vending transaction sequencer: credit balance, coin accept/reject, product select,
// timed dispense and change issue. All outputs are registered.
module vend_controller
  import vend_pkg::*;
#(
  parameter int unsigned PRICE0      = 2,
  parameter int unsigned PRICE1      = 3,
  parameter int unsigned PRICE2      = 5,
  parameter int unsigned PRICE3      = 7,
  parameter int unsigned BAL_MAX     = 99,
  parameter int unsigned DISP_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             one,
  input  logic             two,
  input  logic             five,
  input  logic             ten,
  input  logic             p0,
  input  logic             p1,
  input  logic             p2,
  input  logic             p3,
  input  logic             cancel,
  output logic [BAL_W-1:0] balance,
  output logic             used,
  output logic             get,
  output logic [1:0]       prod,
  output logic             back,
  output logic [BAL_W-1:0] change,
  output logic             reject,
  output logic             short
);

  localparam int unsigned CntW = $clog2(DISP_CYCLES + 1);

  vend_state_e      state_q, state_d;
  logic [BAL_W-1:0] balance_q, balance_d;
  logic [BAL_W-1:0] change_q, change_d;
  logic [1:0]       prod_q, prod_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             reject_q, reject_d;
  logic             short_q, short_d;
  logic             get_q, back_q, used_q;

  logic             coin_valid;
  logic             coin_multi;
  logic [3:0]       coin_value;
  logic [BAL_W:0]   coin_sum;
  logic             coin_fits;

  logic             sel_any;
  logic [1:0]       sel_idx;
  logic [BAL_W-1:0] sel_price;

  vend_coin_enc u_coin_enc (
    .one   (one),
    .two   (two),
    .five  (five),
    .ten   (ten),
    .valid (coin_valid),
    .multi (coin_multi),
    .value (coin_value)
  );

  // One bit wider than the balance so the overflow compare cannot wrap.
  assign coin_sum  = {1'b0, balance_q} + {{(BAL_W - 3){1'b0}}, coin_value};
  assign coin_fits = coin_sum <= (BAL_W + 1)'(BAL_MAX);

  assign sel_any = p0 | p1 | p2 | p3;

  always_comb begin
    sel_idx = 2'd3;
    if (p0) begin
      sel_idx = 2'd0;
    end else if (p1) begin
      sel_idx = 2'd1;
    end else if (p2) begin
      sel_idx = 2'd2;
    end
  end

  always_comb begin
    sel_price = BAL_W'(PRICE3);
    unique case (sel_idx)
      2'd0:    sel_price = BAL_W'(PRICE0);
      2'd1:    sel_price = BAL_W'(PRICE1);
      2'd2:    sel_price = BAL_W'(PRICE2);
      default: sel_price = BAL_W'(PRICE3);
    endcase
  end

  always_comb begin
    state_d   = state_q;
    balance_d = balance_q;
    change_d  = change_q;
    prod_d    = prod_q;
    cnt_d     = cnt_q;
    reject_d  = 1'b0;
    short_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (coin_valid) begin
          if (coin_fits) begin
            balance_d = coin_sum[BAL_W-1:0];
            state_d   = StCredit;
            reject_d  = coin_multi;
          end else begin
            reject_d = 1'b1;
          end
        end
      end

      StCredit: begin
        if (cancel) begin
          state_d  = StChange;
          change_d = balance_q;
          reject_d = coin_valid;
        end else if (sel_any) begin
          // Select is judged on the old balance; any coin alongside it is returned.
          reject_d = coin_valid;
          if (balance_q >= sel_price) begin
            balance_d = balance_q - sel_price;
            prod_d    = sel_idx;
            cnt_d     = CntW'(DISP_CYCLES - 1);
            state_d   = StDispense;
          end else begin
            short_d = 1'b1;
          end
        end else if (coin_valid) begin
          if (coin_fits) begin
            balance_d = coin_sum[BAL_W-1:0];
            reject_d  = coin_multi;
          end else begin
            reject_d = 1'b1;
          end
        end
      end

      StDispense: begin
        reject_d = coin_valid;
        if (cnt_q == '0) begin
          if (balance_q != '0) begin
            state_d  = StChange;
            change_d = balance_q;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end

      StChange: begin
        reject_d  = coin_valid;
        balance_d = '0;
        state_d   = StIdle;
      end

      default: begin
        state_d   = StIdle;
        balance_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StIdle;
      balance_q <= '0;
      change_q  <= '0;
      prod_q    <= 2'd0;
      cnt_q     <= '0;
      reject_q  <= 1'b0;
      short_q   <= 1'b0;
      get_q     <= 1'b0;
      back_q    <= 1'b0;
      used_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      balance_q <= balance_d;
      change_q  <= change_d;
      prod_q    <= prod_d;
      cnt_q     <= cnt_d;
      reject_q  <= reject_d;
      short_q   <= short_d;
      // Indicators are registered from the next state so they line up with it.
      get_q     <= (state_d == StDispense);
      back_q    <= (state_d == StChange);
      used_q    <= (state_d != StIdle);
    end
  end

  assign balance = balance_q;
  assign change  = change_q;
  assign prod    = prod_q;
  assign reject  = reject_q;
  assign short   = short_q;
  assign get     = get_q;
  assign back    = back_q;
  assign used    = used_q;

endmodule
